// File: rtl/video_pkg.sv
// Shared pattern encodings and colour constants for the video test-pattern path.
// Colours are packed {R,G,B}, 8 bits per channel.
package video_pkg;

   typedef enum logic [2:0] {
      PAT_BARS    = 3'd0,
      PAT_CHECKER = 3'd1,
      PAT_RAMP    = 3'd2,
      PAT_BOX     = 3'd3,
      PAT_SOLID   = 3'd4
   } pattern_t;

   localparam logic [23:0] WHITE     = 24'hFFFFFF;
   localparam logic [23:0] YELLOW    = 24'hFFFF00;
   localparam logic [23:0] CYAN      = 24'h00FFFF;
   localparam logic [23:0] GREEN     = 24'h00FF00;
   localparam logic [23:0] MAGENTA   = 24'hFF00FF;
   localparam logic [23:0] RED       = 24'hFF0000;
   localparam logic [23:0] BLUE      = 24'h0000FF;
   localparam logic [23:0] BLACK     = 24'h000000;
   localparam logic [23:0] DARK_BLUE = 24'h000040;

   // Classic bar order, left to right.
   function automatic logic [23:0] barColour(input logic [2:0] idx);
      logic [23:0] colour;
      case (idx)
         3'd0:    colour = WHITE;
         3'd1:    colour = YELLOW;
         3'd2:    colour = CYAN;
         3'd3:    colour = GREEN;
         3'd4:    colour = MAGENTA;
         3'd5:    colour = RED;
         3'd6:    colour = BLUE;
         default: colour = BLACK;
      endcase
      return colour;
   endfunction

   function automatic logic [23:0] greyLevel(input logic [7:0] level);
      return {level, level, level};
   endfunction

endpackage

// File: rtl/video_box_mover.sv
// Bouncing-box position: steps once per frame event and reverses at the active-area edges.
// The edge comparisons use one spare bit so box + size + step can never wrap.
module video_box_mover #(
   parameter int X_BITS   = 12,
   parameter int Y_BITS   = 12,
   parameter int H_ACTIVE = 1280,
   parameter int V_ACTIVE = 720,
   parameter int BOX_SIZE = 64,
   parameter int BOX_STEP = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              i_frameEvt,
   output logic [X_BITS-1:0] o_boxX,
   output logic [Y_BITS:0]   o_boxY
);

   localparam int XW = X_BITS + 1;
   localparam int YW = Y_BITS + 2;
   localparam int BY = Y_BITS + 1;

   localparam logic [XW-1:0]     ADV_X  = XW'(BOX_SIZE + BOX_STEP);
   localparam logic [YW-1:0]     ADV_Y  = YW'(BOX_SIZE + BOX_STEP);
   localparam logic [XW-1:0]     LIM_X  = XW'(H_ACTIVE);
   localparam logic [YW-1:0]     LIM_Y  = YW'(V_ACTIVE);
   localparam logic [X_BITS-1:0] STEP_X = X_BITS'(BOX_STEP);
   localparam logic [BY-1:0]     STEP_Y = BY'(BOX_STEP);

   logic [X_BITS-1:0] r_boxX;
   logic [BY-1:0]     r_boxY;
   logic              r_dirX;
   logic              r_dirY;
   logic [XW-1:0]     w_xFwd;
   logic [YW-1:0]     w_yFwd;

   assign w_xFwd = {1'b0, r_boxX} + ADV_X;
   assign w_yFwd = {1'b0, r_boxY} + ADV_Y;

   // Direction bit 1 means moving towards larger coordinates; a bounce frame holds position.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_boxX <= '0;
         r_boxY <= '0;
         r_dirX <= 1'b1;
         r_dirY <= 1'b1;
      end else if (i_frameEvt) begin
         if (r_dirX) begin
            if (w_xFwd > LIM_X) r_dirX <= 1'b0;
            else                r_boxX <= r_boxX + STEP_X;
         end else begin
            if (r_boxX < STEP_X) r_dirX <= 1'b1;
            else                 r_boxX <= r_boxX - STEP_X;
         end

         if (r_dirY) begin
            if (w_yFwd > LIM_Y) r_dirY <= 1'b0;
            else                r_boxY <= r_boxY + STEP_Y;
         end else begin
            if (r_boxY < STEP_Y) r_dirY <= 1'b1;
            else                 r_boxY <= r_boxY - STEP_Y;
         end
      end
   end

   assign o_boxX = r_boxX;
   assign o_boxY = r_boxY;

endmodule

// File: rtl/video_pattern_gen.sv
// Test-pattern pixel source between the sync generator and the ADV7511 bus.
// Two-stage pipeline: stage 1 computes every pattern colour, stage 2 selects and gates on de.
module video_pattern_gen #(
   parameter int X_BITS   = 12,
   parameter int Y_BITS   = 12,
   parameter int H_ACTIVE = 1280,
   parameter int V_ACTIVE = 720,
   parameter int BOX_SIZE = 64,
   parameter int BOX_STEP = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              hs_in,
   input  logic              vs_in,
   input  logic              de_in,
   input  logic [X_BITS-1:0] x_in,
   input  logic [Y_BITS:0]   y_in,
   input  logic [2:0]        pattern_sel,
   input  logic [23:0]       solid_rgb,
   output logic              hs_out,
   output logic              vs_out,
   output logic              de_out,
   output logic [23:0]       rgb_out,
   output logic [15:0]       frame_cnt
);

   import video_pkg::*;

   localparam int XW       = X_BITS + 1;
   localparam int YW       = Y_BITS + 2;
   localparam int BY       = Y_BITS + 1;
   localparam int BAR_W    = H_ACTIVE / 8;
   localparam int BAR_CW   = $clog2(BAR_W);
   localparam int GRAD_MUL = (256 * 65536) / H_ACTIVE;
   localparam int PROD_W   = X_BITS + 16;

   localparam logic [BAR_CW-1:0] BAR_LAST = BAR_CW'(BAR_W - 1);
   localparam logic [X_BITS-1:0] X_MAX    = X_BITS'(H_ACTIVE - 1);
   localparam logic [BY-1:0]     Y_MAX    = BY'(V_ACTIVE - 1);
   localparam logic [XW-1:0]     BOX_W_X  = XW'(BOX_SIZE);
   localparam logic [YW-1:0]     BOX_W_Y  = YW'(BOX_SIZE);
   localparam logic [X_BITS-1:0] GREY_MAX = X_BITS'(255);

   logic              r_hsS1, r_vsS1, r_deS1;
   logic [2:0]        r_patS1;
   logic [2:0]        r_patternQ;
   logic [15:0]       r_frameCnt;
   logic [BAR_CW-1:0] r_barCnt;
   logic [2:0]        r_barIdx;
   logic [23:0]       r_barsRgb, r_checkRgb, r_rampRgb, r_boxRgb, r_solidRgb;
   logic              r_hsOut, r_vsOut, r_deOut;
   logic [23:0]       r_rgbOut;

   logic              w_frameEvt;
   logic              w_deRise;
   logic [BAR_CW-1:0] w_barCntCur;
   logic [2:0]        w_barIdxCur;
   logic [X_BITS-1:0] w_xClamp;
   logic [BY-1:0]     w_yClamp;
   logic [PROD_W-1:0] w_rampProd;
   logic [X_BITS-1:0] w_rampHi;
   logic [7:0]        w_grey;
   logic [X_BITS-1:0] w_boxX;
   logic [BY-1:0]     w_boxY;
   logic              w_inBoxX, w_inBoxY;
   logic [23:0]       w_pixSel;

   // r_vsS1 and r_deS1 double as the previous-sample registers for edge detection.
   assign w_frameEvt = vs_in & ~r_vsS1;
   assign w_deRise   = de_in & ~r_deS1;

   assign w_xClamp = (x_in > X_MAX) ? X_MAX : x_in;
   assign w_yClamp = (y_in > Y_MAX) ? Y_MAX : y_in;

   assign w_rampProd = PROD_W'(w_xClamp) * PROD_W'(GRAD_MUL);
   assign w_rampHi   = X_BITS'(w_rampProd >> 16);
   assign w_grey     = (w_rampHi > GREY_MAX) ? 8'hFF : w_rampHi[7:0];

   assign w_inBoxX = ({1'b0, w_xClamp} >= {1'b0, w_boxX}) &&
                     ({1'b0, w_xClamp} <  ({1'b0, w_boxX} + BOX_W_X));
   assign w_inBoxY = ({1'b0, w_yClamp} >= {1'b0, w_boxY}) &&
                     ({1'b0, w_yClamp} <  ({1'b0, w_boxY} + BOX_W_Y));

   video_box_mover #(
      .X_BITS   (X_BITS),
      .Y_BITS   (Y_BITS),
      .H_ACTIVE (H_ACTIVE),
      .V_ACTIVE (V_ACTIVE),
      .BOX_SIZE (BOX_SIZE),
      .BOX_STEP (BOX_STEP)
   ) u_boxMover (
      .clk        (clk),
      .reset_n    (reset_n),
      .i_frameEvt (w_frameEvt),
      .o_boxX     (w_boxX),
      .o_boxY     (w_boxY)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_patternQ <= '0;
         r_frameCnt <= '0;
      end else if (w_frameEvt) begin
         r_patternQ <= pattern_sel;
         r_frameCnt <= r_frameCnt + 16'd1;
      end
   end

   // A de rising edge restarts the bars for the current pixel as well as the stored count.
   always_comb begin
      w_barCntCur = r_barCnt;
      w_barIdxCur = r_barIdx;
      if (w_deRise) begin
         w_barCntCur = '0;
         w_barIdxCur = '0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_barCnt <= '0;
         r_barIdx <= '0;
      end else if (de_in) begin
         if (w_barCntCur == BAR_LAST) begin
            r_barCnt <= '0;
            r_barIdx <= (w_barIdxCur == 3'd7) ? 3'd7 : w_barIdxCur + 3'd1;
         end else begin
            r_barCnt <= w_barCntCur + BAR_CW'(1);
            r_barIdx <= w_barIdxCur;
         end
      end
   end

   // Stage 1 latches the old pattern_q, so a frame event's own pixel keeps the previous pattern.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_hsS1     <= 1'b0;
         r_vsS1     <= 1'b0;
         r_deS1     <= 1'b0;
         r_patS1    <= '0;
         r_barsRgb  <= '0;
         r_checkRgb <= '0;
         r_rampRgb  <= '0;
         r_boxRgb   <= '0;
         r_solidRgb <= '0;
      end else begin
         r_hsS1     <= hs_in;
         r_vsS1     <= vs_in;
         r_deS1     <= de_in;
         r_patS1    <= r_patternQ;
         r_barsRgb  <= barColour(w_barIdxCur);
         r_checkRgb <= (w_xClamp[5] ^ w_yClamp[5]) ? WHITE : BLACK;
         r_rampRgb  <= greyLevel(w_grey);
         r_boxRgb   <= (w_inBoxX && w_inBoxY) ? WHITE : DARK_BLUE;
         r_solidRgb <= solid_rgb;
      end
   end

   always_comb begin
      w_pixSel = BLACK;
      case (r_patS1)
         PAT_BARS:    w_pixSel = r_barsRgb;
         PAT_CHECKER: w_pixSel = r_checkRgb;
         PAT_RAMP:    w_pixSel = r_rampRgb;
         PAT_BOX:     w_pixSel = r_boxRgb;
         PAT_SOLID:   w_pixSel = r_solidRgb;
         default:     w_pixSel = BLACK;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_hsOut  <= 1'b0;
         r_vsOut  <= 1'b0;
         r_deOut  <= 1'b0;
         r_rgbOut <= '0;
      end else begin
         r_hsOut  <= r_hsS1;
         r_vsOut  <= r_vsS1;
         r_deOut  <= r_deS1;
         r_rgbOut <= r_deS1 ? w_pixSel : BLACK;
      end
   end

   assign hs_out    = r_hsOut;
   assign vs_out    = r_vsOut;
   assign de_out    = r_deOut;
   assign rgb_out   = r_rgbOut;
   assign frame_cnt = r_frameCnt;

endmodule
